time_set_ctrl: RTL
==================

Name: time_set_ctrl

Overview:
Front-panel time-setting controller: the writer side of the hour/minute/second counters' enable and load interface.
- Debounces three push-buttons (mode, inc, dec).
- Snapshots the running time and lets the user edit hour, then minute, then second.
- Commits the edited time by pulsing the counters' load inputs with new preset data.
- Holds the counters (en_* low) while editing. Sits beside the counter chain at the top level, clocked from the 50 MHz input.

Parameters:
DEBOUNCE_CYCLES, 1000000, cycles a synchronised key must stay stable before its level is accepted (20 ms at 50 MHz); minimum 2
REPEAT_DELAY, 25000000, cycles inc/dec must be held before auto-repeat starts (AUTO_REPEAT_EN only)
REPEAT_PERIOD, 5000000, cycles between auto-repeat steps (AUTO_REPEAT_EN only)

Ports:
clk_in_50M  input  1  system clock, single clock domain
rst_n  input  1  asynchronous active-low reset
key_mode  input  1  raw mode button, active-high, asynchronous, bouncing
key_inc  input  1  raw increment button, active-high, asynchronous
key_dec  input  1  raw decrement button, active-high, asynchronous
cur_hour  input  7  live hour counter value, binary 0..23
cur_min  input  7  live minute counter value, binary 0..59
cur_sec  input  7  live second counter value, binary 0..59
en_hour, en_min, en_sec  output  1 each  counter enables; 1 = count, 0 = hold
load_hour, load_min, load_sec  output  1 each  one-cycle load strobes
data_hour, data_min, data_sec  output  7 each  preset data; always equal to the edit registers
set_active  output  1  high in any SET state; top level muxes data_* to the displays
edit_field  output  2  0 = none, 1 = hour, 2 = minute, 3 = second (for display blinking)

Behaviour:
Reset (async, rst_n low):
- State RUN; edit registers 0; data_* 0; load_* 0; en_* 1; set_active 0; edit_field 0.
- Synchroniser and debounce state cleared to "released".

Key path (per key):
- 2-FF synchroniser, then a stability counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
- A debounced 0->1 edge produces a one-cycle press pulse. Release produces nothing.
- Latency from a clean input edge to the press pulse: DEBOUNCE_CYCLES+2 cycles ±1.

FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
- RUN + mode press:
  - Copy cur_* into the edit registers.
  - en_* go to 0 in the same cycle the state becomes SET_HOUR.
  - inc/dec presses in RUN are ignored.
- SET_HOUR + mode press -> SET_MIN. SET_MIN + mode press -> SET_SEC. SET_SEC + mode press -> COMMIT.
- Editing in a SET state:
  - inc press: active field +1, wrapping hour 23->0 and min/sec 59->0.
  - dec press: active field -1, wrapping hour 0->23 and min/sec 0->59.
  - Only the active field changes.
- COMMIT lasts exactly one cycle:
  - load_hour, load_min and load_sec are all 1 simultaneously; data_* hold the edit values.
  - Next state is RUN; en_* return to 1 on that next cycle.
  - Loads are never asserted in any other state.
- set_active is 1 in SET_HOUR, SET_MIN and SET_SEC only. edit_field follows the state: 0 in RUN and COMMIT.

Simultaneous events:
- inc and dec pulses in the same cycle: no change.
- mode pulse together with inc/dec: mode wins, the inc/dec is dropped.

Other boundary rules:
- Edit register values outside range (not possible after snapshot of a legal count) are treated as max+1 and wrap to 0 on inc.
- Reset mid-edit: immediate return to RUN; no load pulse; en_* back to 1; edits discarded.

Optional Feature:
AUTO_REPEAT_EN
- Defined: in a SET state, when debounced inc (or dec) stays held for REPEAT_DELAY cycles after its press pulse, an extra step pulse is generated. Further pulses follow every REPEAT_PERIOD cycles while the key is held.
- Repeat timers reset on release, on a mode press, and on leaving SET states.
- If both keys are held, no repeats are generated.
- Undefined: one step per press only; repeat counters are not synthesised.

Test Plan:
1. DEBOUNCE_CYCLES=4. key_inc toggles every cycle for 10 cycles, then rests at 0 -> no press pulse; edit value unchanged.
2. cur=12:34:56 in RUN, then mode press -> SET_HOUR, data_*=12/34/56, en_*=0, set_active=1, edit_field=1.
3. In SET_HOUR at 23, inc press -> 0. In SET_MIN at 0, dec press -> 59. In SET_SEC at 59, inc press -> 0.
4. Full sequence: edit to 07:08:09, then mode press in SET_SEC -> exactly one cycle with load_*=1 and data=7/8/9; next cycle state RUN, en_*=1, loads 0.
5. inc+dec pulses in the same cycle -> value unchanged. mode+inc in the same cycle in SET_HOUR -> SET_MIN with hour unchanged.
6. rst_n low for 1 cycle while in SET_MIN -> RUN, en_*=1, no load pulse seen. With AUTO_REPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4, holding inc for 20 cycles after press -> 1 press step plus repeats at +8, +12, +16, +20.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Front-panel time setter: debounces mode/inc/dec, edits a snapshot of hh:mm:ss, then loads it into the counters.
// Optional auto-repeat of held inc/dec keys is compiled in with `define AUTO_REPEAT_EN.
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk_in_50M,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic [6:0] cur_hour,
  input  logic [6:0] cur_min,
  input  logic [6:0] cur_sec,
  output logic       en_hour,
  output logic       en_min,
  output logic       en_sec,
  output logic       load_hour,
  output logic       load_min,
  output logic       load_sec,
  output logic [6:0] data_hour,
  output logic [6:0] data_min,
  output logic [6:0] data_sec,
  output logic       set_active,
  output logic [1:0] edit_field
);

  localparam int DBW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int K_MODE = 0;
  localparam int K_INC  = 1;
  localparam int K_DEC  = 2;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_HOUR,
    ST_SET_MIN,
    ST_SET_SEC,
    ST_COMMIT
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [6:0] r_hour, r_min, r_sec;
  logic [6:0] w_hour_nxt, w_min_nxt, w_sec_nxt;

  logic [2:0]     w_keys;
  logic [2:0]     r_sync1, r_sync2, r_db, r_db_d;
  logic [DBW-1:0] r_db_cnt [3];
  logic [2:0]     w_press;
  logic [1:0]     w_rep;
  logic           w_up, w_dn;

  assign w_keys = {key_dec, key_inc, key_mode};

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk_in_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_keys;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            r_db[i]     <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_press = r_db & ~r_db_d;

`ifdef AUTO_REPEAT_EN
  localparam int RPW = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);

  logic [RPW-1:0] r_rep_cnt [2];
  logic [1:0]     r_rep_arm;
  logic           w_hold_ok;

  assign w_hold_ok = set_active & ~w_press[K_MODE] & ~(r_db[K_INC] & r_db[K_DEC]);

  // r_rep_cnt counts cycles since the last step; zero means idle. r_rep_arm selects delay vs period.
  always_comb begin
    w_rep = '0;
    for (int j = 0; j < 2; j++) begin
      if (w_hold_ok && r_db[j+1] && r_rep_cnt[j] != '0)
        w_rep[j] = r_rep_arm[j] ? (r_rep_cnt[j] == RPW'(REPEAT_PERIOD))
                                : (r_rep_cnt[j] == RPW'(REPEAT_DELAY));
    end
  end

  always_ff @(posedge clk_in_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_arm <= '0;
      for (int j = 0; j < 2; j++) r_rep_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!w_hold_ok || !r_db[j+1]) begin
          r_rep_cnt[j] <= '0;
          r_rep_arm[j] <= 1'b0;
        end else if (w_press[j+1]) begin
          r_rep_cnt[j] <= RPW'(1);
          r_rep_arm[j] <= 1'b0;
        end else if (w_rep[j]) begin
          r_rep_cnt[j] <= RPW'(1);
          r_rep_arm[j] <= 1'b1;
        end else if (r_rep_cnt[j] != '0) begin
          r_rep_cnt[j] <= r_rep_cnt[j] + 1'b1;
        end
      end
    end
  end
`else
  assign w_rep = 2'b00;
`endif

  assign w_up = (w_press[K_INC] | w_rep[0]) & ~(w_press[K_DEC] | w_rep[1]);
  assign w_dn = (w_press[K_DEC] | w_rep[1]) & ~(w_press[K_INC] | w_rep[0]);

  // Out-of-range values behave as max+1: inc wraps to 0, dec lands on max.
  function automatic logic [6:0] f_step(input logic [6:0] v, input logic [6:0] mx, input logic up);
    if (up) return (v >= mx) ? 7'd0 : v + 7'd1;
    else    return (v == 7'd0 || v > mx) ? mx : v - 7'd1;
  endfunction

  always_ff @(posedge clk_in_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_hour  <= '0;
      r_min   <= '0;
      r_sec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hour  <= w_hour_nxt;
      r_min   <= w_min_nxt;
      r_sec   <= w_sec_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hour_nxt  = r_hour;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    case (r_state)
      ST_RUN: begin
        if (w_press[K_MODE]) begin
          w_state_nxt = ST_SET_HOUR;
          w_hour_nxt  = cur_hour;
          w_min_nxt   = cur_min;
          w_sec_nxt   = cur_sec;
        end
      end
      ST_SET_HOUR: begin
        if (w_press[K_MODE])  w_state_nxt = ST_SET_MIN;
        else if (w_up | w_dn) w_hour_nxt = f_step(r_hour, 7'd23, w_up);
      end
      ST_SET_MIN: begin
        if (w_press[K_MODE])  w_state_nxt = ST_SET_SEC;
        else if (w_up | w_dn) w_min_nxt = f_step(r_min, 7'd59, w_up);
      end
      ST_SET_SEC: begin
        if (w_press[K_MODE])  w_state_nxt = ST_COMMIT;
        else if (w_up | w_dn) w_sec_nxt = f_step(r_sec, 7'd59, w_up);
      end
      ST_COMMIT: w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  assign en_hour    = (r_state == ST_RUN);
  assign en_min     = (r_state == ST_RUN);
  assign en_sec     = (r_state == ST_RUN);
  assign load_hour  = (r_state == ST_COMMIT);
  assign load_min   = (r_state == ST_COMMIT);
  assign load_sec   = (r_state == ST_COMMIT);
  assign data_hour  = r_hour;
  assign data_min   = r_min;
  assign data_sec   = r_sec;
  assign set_active = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN) || (r_state == ST_SET_SEC);
  assign edit_field = (r_state == ST_SET_HOUR) ? 2'd1 :
                      (r_state == ST_SET_MIN)  ? 2'd2 :
                      (r_state == ST_SET_SEC)  ? 2'd3 : 2'd0;

endmodule
